str_vgen: RTL
=============

# str_vgen

Stream video source for the 3DNR datapath. It originates raster frames on the codebase's ready/valid stream interface, with `user` marking start-of-frame and `last` marking end-of-line. It drives `str_ppl` stages and the 3DNR core directly in test-pattern and bring-up builds, and it honours downstream back-pressure on every beat.

## Interface
Parameters:
- `WIDTH`, 32: data width, minimum 16.
- `H_BITS`, 12: width of the horizontal size and pixel counter.
- `V_BITS`, 12: width of the vertical size and line counter.

Ports:
- `i_clk` in 1: single clock.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_start` in 1: one-cycle frame start request.
- `i_cont` in 1: continuous mode, sampled with `i_start`.
- `i_stop` in 1: clears continuous mode; the current frame completes.
- `i_hsize` in `H_BITS`: pixels per line.
- `i_vsize` in `V_BITS`: lines per frame.
- `i_line_gap` in 8: idle cycles inserted after each non-final line.
- `i_pattern` in 2: pattern select.
- `o_str_data` out `WIDTH`: pixel data.
- `o_str_vld` out 1: beat valid.
- `o_str_user` out 1: start of frame, high on pixel (0,0) only.
- `o_str_last` out 1: end of line, high on pixel x = hsize-1.
- `i_str_rdy` in 1: downstream ready.
- `o_busy` out 1: high from the cycle after an accepted start until the return to IDLE.
- `o_frm_done` out 1: one-cycle pulse per completed frame.

## Operation
- Configuration inputs (`i_hsize`, `i_vsize`, `i_line_gap`, `i_pattern`, `i_cont`) are latched when a start is accepted, and again at each continuous restart.
- A start is accepted only in IDLE with `i_hsize` != 0 and `i_vsize` != 0. Otherwise it is ignored.
- State machine:
  - IDLE → LINE on an accepted start.
  - LINE → GAP after the last-beat transfer of a non-final line when the latched gap != 0.
  - LINE → LINE after that transfer when the latched gap == 0.
  - GAP → LINE when the gap counter expires.
  - LINE → DONE after the last-beat transfer of the final line.
  - DONE → LINE if continuous mode is still set (config re-latched); otherwise DONE → IDLE.
- Counters `x` (0..hsize-1) and `y` (0..vsize-1) advance only on a transfer (`o_str_vld & i_str_rdy`). `x` wraps to 0 on `last`, and `y` increments at that point.
- Patterns (computed from the current x, y; truncated or zero-extended to `WIDTH`):
  - 0: {y[15:0], x[15:0]}.
  - 1: x zero-extended.
  - 2: y zero-extended.
  - 3: all-ones if x[3]^y[3], else zero.
- While `o_str_vld`=1 and `i_str_rdy`=0, all `o_str_*` outputs hold stable. Valid is never withdrawn without a transfer.
- `i_stop` in any state clears the latched continuous flag. The frame in flight completes normally, and `o_frm_done` still pulses.
- `i_start` while busy is ignored.

## Timing
- Reset (asynchronous, immediate): `o_str_data`=0, `o_str_vld`=0, `o_str_user`=0, `o_str_last`=0, `o_busy`=0, `o_frm_done`=0, state IDLE, counters 0, continuous flag 0.
- All outputs are registered, with no combinational path from `i_str_rdy` to outputs.
- Start accepted at cycle N: `o_busy` and the first beat (`o_str_vld`=1, `o_str_user`=1) appear at N+1.
- With `i_str_rdy` tied high and gap 0, a frame occupies exactly hsize×vsize consecutive valid cycles.
- Gap g: after the last beat of a non-final line transfers at cycle M, `o_str_vld` is low for cycles M+1..M+g, and the next beat is at M+g+1.
- Final-beat transfer at cycle M:
  - `o_frm_done`=1 at M+1 (DONE).
  - Continuous mode: the next frame's first beat appears at M+2.
  - Otherwise: `o_busy`=0 at M+2.
- hsize=1: every beat has `last`=1. hsize=1 with vsize=1: a single beat with `user`=1 and `last`=1.
- Reset mid-frame abandons the frame. No `o_frm_done` pulse is produced.

## Configuration
- `STR_VGEN_FRM_TAG_EN` defined: data bits [WIDTH-1:WIDTH-8] are replaced by an 8-bit frame counter. The counter is 0 after reset, increments at each DONE, and wraps 255→0.
- Not defined: data is the pattern only. The frame counter is not implemented.

## Test plan
- Reset, then hsize=4, vsize=2, gap=0, pattern 0, rdy=1 → 8 consecutive beats with data 0x00000000..0x00000003, then 0x00010000..0x00010003. `user` on beat 0 only, `last` on beats 3 and 7, `o_frm_done` one cycle after beat 7.
- Same frame with rdy toggling 1,0,0,1 repeatedly → identical beat sequence, and outputs stable across every stalled cycle.
- hsize=3, vsize=3, gap=2 → two low-valid cycles after each of lines 0 and 1, none after line 2.
- Continuous mode, 2×2 frame, `i_stop` pulsed during frame 2 → frames 1 and 2 complete, two `o_frm_done` pulses, then IDLE. With `STR_VGEN_FRM_TAG_EN`, data[31:24]=0 then 1.
- `i_start` with hsize=0 → no beats and `o_busy` stays 0. `i_start` while busy → ignored, and the frame count is unchanged.
- `i_rst` asserted mid-line with rdy=0 → all outputs 0 immediately. A new start afterwards produces a clean frame beginning at (0,0) with `user`=1.

Source files
------------

// File: rtl/str_vgen.sv
// str_vgen: raster test-pattern stream source with ready/valid back-pressure; STR_VGEN_FRM_TAG_EN puts an 8-bit frame tag in the top data byte
module str_vgen #(
  parameter int WIDTH  = 32,
  parameter int H_BITS = 12,
  parameter int V_BITS = 12
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_cont,
  input  logic              i_stop,
  input  logic [H_BITS-1:0] i_hsize,
  input  logic [V_BITS-1:0] i_vsize,
  input  logic [7:0]        i_line_gap,
  input  logic [1:0]        i_pattern,
  output logic [WIDTH-1:0]  o_str_data,
  output logic              o_str_vld,
  output logic              o_str_user,
  output logic              o_str_last,
  input  logic              i_str_rdy,
  output logic              o_busy,
  output logic              o_frm_done
);
  typedef enum logic [1:0] {IDLE, LINE, GAP, DONE} state_t;
  state_t st;
  logic [H_BITS-1:0] hs, x;
  logic [V_BITS-1:0] vs, y;
  logic [7:0] gap, gc;
  logic [1:0] pat;
  logic cont, go;
`ifdef STR_VGEN_FRM_TAG_EN
  logic [7:0] tag;
`endif
  function automatic logic [WIDTH-1:0] pix(input logic [1:0] p, input logic [H_BITS-1:0] px, input logic [V_BITS-1:0] py);
    logic [15:0] xx, yy;
    logic [WIDTH-1:0] d;
    xx = 16'(px);
    yy = 16'(py);
    d = p == 2'd0 ? WIDTH'({yy, xx}) : p == 2'd1 ? WIDTH'(px) : p == 2'd2 ? WIDTH'(py) : {WIDTH{xx[3] ^ yy[3]}};
`ifdef STR_VGEN_FRM_TAG_EN
    d[WIDTH-1 -: 8] = tag;
`endif
    return d;
  endfunction
  // a frame begins from IDLE on a start, or from DONE while continuous mode survives
  assign go = ((st == IDLE && i_start) || (st == DONE && cont && !i_stop)) && i_hsize != '0 && i_vsize != '0;
  // raster FSM: counters advance only on transfers, every output is registered
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      st <= IDLE;
      hs <= '0;
      vs <= '0;
      x <= '0;
      y <= '0;
      gap <= '0;
      gc <= '0;
      pat <= '0;
      cont <= 1'b0;
      o_str_data <= '0;
      o_str_vld <= 1'b0;
      o_str_user <= 1'b0;
      o_str_last <= 1'b0;
      o_busy <= 1'b0;
      o_frm_done <= 1'b0;
`ifdef STR_VGEN_FRM_TAG_EN
      tag <= '0;
`endif
    end else begin
      o_frm_done <= 1'b0;
      if (i_stop) cont <= 1'b0;
      if (go) begin
        hs <= i_hsize;
        vs <= i_vsize;
        gap <= i_line_gap;
        pat <= i_pattern;
        cont <= i_cont & ~i_stop;
        x <= '0;
        y <= '0;
        st <= LINE;
        o_busy <= 1'b1;
        o_str_vld <= 1'b1;
        o_str_user <= 1'b1;
        o_str_last <= i_hsize == H_BITS'(1);
        o_str_data <= pix(i_pattern, '0, '0);
      end else begin
        case (st)
          LINE: if (i_str_rdy) begin
            o_str_user <= 1'b0;
            if (o_str_last) begin
              x <= '0;
              if (y == vs - 1'b1) begin
                st <= DONE;
                o_str_vld <= 1'b0;
                o_str_last <= 1'b0;
                o_frm_done <= 1'b1;
`ifdef STR_VGEN_FRM_TAG_EN
                tag <= tag + 8'd1;
`endif
              end else begin
                y <= y + 1'b1;
                if (gap != 8'd0) begin
                  st <= GAP;
                  gc <= gap;
                  o_str_vld <= 1'b0;
                  o_str_last <= 1'b0;
                end else begin
                  o_str_last <= hs == H_BITS'(1);
                  o_str_data <= pix(pat, '0, y + 1'b1);
                end
              end
            end else begin
              x <= x + 1'b1;
              o_str_last <= x + 1'b1 == hs - 1'b1;
              o_str_data <= pix(pat, x + 1'b1, y);
            end
          end
          GAP: if (gc == 8'd1) begin
            st <= LINE;
            o_str_vld <= 1'b1;
            o_str_last <= hs == H_BITS'(1);
            o_str_data <= pix(pat, '0, y);
          end else begin
            gc <= gc - 8'd1;
          end
          DONE: begin
            st <= IDLE;
            o_busy <= 1'b0;
          end
          default: st <= IDLE;
        endcase
      end
    end
  end
endmodule
